// File: rtl/imi_symb_collector_pkg.sv
// Shared constants and register-map bundle for the imitator receive path.
// Pack geometry is reused from the transmit-side wiper.
package imi_symb_collector_pkg;

  localparam int IMI_SYMB_PER_PACK = 32;
  localparam int IMI_SYMB_PER_PACK_WIDTH =
    $clog2(IMI_SYMB_PER_PACK);
  localparam int IMI_PACK_CNT_W = 16;

  typedef struct packed {
    logic [IMI_SYMB_PER_PACK-1:0] DATA_0;
    logic [IMI_SYMB_PER_PACK-1:0] DATA_1;
    logic [1:0]                   VALID;
    logic                         OVERFLOW;
    logic                         SYNC_ERR;
    logic [IMI_PACK_CNT_W-1:0]    PACK_CNT;
  } IMI_RX_DATA_STRUCT;

endpackage

// File: rtl/imi_symb_collector_deser.sv
// Symbol deserialiser: LSB-first shift register, symbol counter, completion strobe.
// Ports: clk, rst, epoch_pulse, sec2_pulse, symb_in -> pack_done, pack_word, mid_pack.
module imi_symb_collector_deser
  import imi_symb_collector_pkg::*;
#(
  parameter int SYMB_PER_PACK = IMI_SYMB_PER_PACK,
  parameter int CNT_W = $clog2(SYMB_PER_PACK)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     epoch_pulse,
  input  logic                     sec2_pulse,
  input  logic                     symb_in,
  output logic                     pack_done,
  output logic [SYMB_PER_PACK-1:0] pack_word,
  output logic                     mid_pack
);

  logic [SYMB_PER_PACK-1:0] sh;
  logic [CNT_W-1:0]         cnt;
  logic                     accept;

  // sec2 owns the cycle: a coincident epoch is dropped
  assign accept    = epoch_pulse & ~sec2_pulse;
  assign pack_done = accept &&
                     (cnt == CNT_W'(SYMB_PER_PACK - 1));
  assign pack_word = {symb_in, sh[SYMB_PER_PACK-1:1]};
  assign mid_pack  = (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst || sec2_pulse) begin
      cnt <= '0;
      sh  <= '0;
    end else if (pack_done) begin
      cnt <= '0;
      sh  <= '0;
    end else if (accept) begin
      cnt <= cnt + CNT_W'(1);
      sh  <= pack_word;
    end
  end

endmodule

// File: rtl/imi_symb_collector.sv
// Receive-side symbol collector: packs symbols into two ping-pong readout slots.
// Ports: epoch/sec2 strobes, symb_in, rd_ack[1:0], clr_flags -> data_0/1, valid, flags, pack_cnt.
module imi_symb_collector
  import imi_symb_collector_pkg::*;
#(
  parameter int SYMB_PER_PACK = IMI_SYMB_PER_PACK,
  parameter int CNT_W = $clog2(SYMB_PER_PACK),
  parameter int PACK_CNT_W = IMI_PACK_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     epoch_pulse,
  input  logic                     sec2_pulse,
  input  logic                     symb_in,
  input  logic [1:0]               rd_ack,
  input  logic                     clr_flags,
  output logic [SYMB_PER_PACK-1:0] data_0,
  output logic [SYMB_PER_PACK-1:0] data_1,
  output logic [1:0]               valid,
  output logic                     overflow,
  output logic                     sync_err,
  output logic [PACK_CNT_W-1:0]    pack_cnt
);

  logic                     done;
  logic [SYMB_PER_PACK-1:0] word;
  logic                     mid_pack;
  logic                     ptr;
  logic [1:0]               wr;
  logic                     ov_set;
  logic                     se_set;

  imi_symb_collector_deser #(
    .SYMB_PER_PACK(SYMB_PER_PACK),
    .CNT_W        (CNT_W)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .epoch_pulse(epoch_pulse),
    .sec2_pulse (sec2_pulse),
    .symb_in    (symb_in),
    .pack_done  (done),
    .pack_word  (word),
    .mid_pack   (mid_pack)
  );

  // a write to a slot overrides a same-cycle ack of that slot
  always_comb begin
    wr     = {done & ptr, done & ~ptr};
    ov_set = done & valid[ptr] & ~rd_ack[ptr];
    se_set = sec2_pulse & mid_pack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 1'b0;
      data_0   <= '0;
      data_1   <= '0;
      valid    <= '0;
      overflow <= 1'b0;
      sync_err <= 1'b0;
      pack_cnt <= '0;
    end else begin
      if (sec2_pulse)
        ptr <= 1'b0;
      else if (done)
        ptr <= ~ptr;
      if (wr[0])
        data_0 <= word;
      if (wr[1])
        data_1 <= word;
      valid    <= wr | (valid & ~rd_ack);
      overflow <= ov_set | (overflow & ~clr_flags);
      sync_err <= se_set | (sync_err & ~clr_flags);
      if (done)
        pack_cnt <= pack_cnt + PACK_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imi_symb_collector.sv
// Directed bench for imi_symb_collector.
// Table of pack vectors plus hand-written corner sequences.
module tb_imi_symb_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        epoch_pulse;
  logic        sec2_pulse;
  logic        symb_in;
  logic [1:0]  rd_ack;
  logic        clr_flags;
  logic [31:0] data_0;
  logic [31:0] data_1;
  logic [1:0]  valid;
  logic        overflow;
  logic        sync_err;
  logic [15:0] pack_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] w;
    logic [1:0]  ack;
    logic        clr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  v;
    logic        ov;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  imi_symb_collector dut (
    .clk        (clk),
    .rst        (rst),
    .epoch_pulse(epoch_pulse),
    .sec2_pulse (sec2_pulse),
    .symb_in    (symb_in),
    .rd_ack     (rd_ack),
    .clr_flags  (clr_flags),
    .data_0     (data_0),
    .data_1     (data_1),
    .valid      (valid),
    .overflow   (overflow),
    .sync_err   (sync_err),
    .pack_cnt   (pack_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send_bits(logic [31:0] w, int n);
    for (int i = 0; i < n; i++) begin
      epoch_pulse = 1'b1;
      symb_in     = w[i];
      tick();
    end
    epoch_pulse = 1'b0;
    symb_in     = 1'b0;
  endtask

  task automatic send_word(logic [31:0] w, logic [1:0] ack,
                           logic clr);
    send_bits(w, 31);
    epoch_pulse = 1'b1;
    symb_in     = w[31];
    rd_ack      = ack;
    clr_flags   = clr;
    tick();
    epoch_pulse = 1'b0;
    symb_in     = 1'b0;
    rd_ack      = 2'b00;
    clr_flags   = 1'b0;
  endtask

  task automatic pulse_sec2(logic with_epoch, logic b);
    sec2_pulse  = 1'b1;
    epoch_pulse = with_epoch;
    symb_in     = b;
    tick();
    sec2_pulse  = 1'b0;
    epoch_pulse = 1'b0;
    symb_in     = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_d0"}, data_0, 32'h0);
    check({tag, "_d1"}, data_1, 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h0);
    check({tag, "_ovf"}, 32'(overflow), 32'h0);
    check({tag, "_serr"}, 32'(sync_err), 32'h0);
    check({tag, "_pcnt"}, 32'(pack_cnt), 32'h0);
  endtask

  initial begin
    tbl[0] = '{32'hA5C30F01, 2'b00, 1'b0, 32'hA5C30F01,
               32'h00000000, 2'b01, 1'b0, 16'd1};
    tbl[1] = '{32'h9ABCDEF0, 2'b00, 1'b0, 32'hA5C30F01,
               32'h9ABCDEF0, 2'b11, 1'b0, 16'd2};
    tbl[2] = '{32'h12345678, 2'b00, 1'b0, 32'h12345678,
               32'h9ABCDEF0, 2'b11, 1'b1, 16'd3};
    tbl[3] = '{32'hDEADBEEF, 2'b10, 1'b1, 32'h12345678,
               32'hDEADBEEF, 2'b11, 1'b0, 16'd4};
    tbl[4] = '{32'hCAFEF00D, 2'b01, 1'b0, 32'hCAFEF00D,
               32'hDEADBEEF, 2'b11, 1'b0, 16'd5};
    tbl[5] = '{32'h0000FFFF, 2'b01, 1'b1, 32'hCAFEF00D,
               32'h0000FFFF, 2'b10, 1'b1, 16'd6};
    tbl[6] = '{32'h80000001, 2'b11, 1'b0, 32'h80000001,
               32'h0000FFFF, 2'b01, 1'b1, 16'd7};

    rst         = 1'b1;
    epoch_pulse = 1'b0;
    sec2_pulse  = 1'b0;
    symb_in     = 1'b0;
    rd_ack      = 2'b00;
    clr_flags   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_zero("reset");

    // first pack: nothing visible before the 32nd epoch
    pulse_sec2(1'b0, 1'b0);
    check("sec2_idle_serr", 32'(sync_err), 32'h0);
    send_bits(32'hA5C30F01, 31);
    check("early_valid", 32'(valid), 32'h0);
    check("early_pcnt", 32'(pack_cnt), 32'h0);
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        epoch_pulse = 1'b1;
        symb_in     = 1'b1;
        tick();
        epoch_pulse = 1'b0;
        symb_in     = 1'b0;
      end else begin
        send_word(tbl[i].w, tbl[i].ack, tbl[i].clr);
      end
      check($sformatf("v%0d_d0", i), data_0, tbl[i].d0);
      check($sformatf("v%0d_d1", i), data_1, tbl[i].d1);
      check($sformatf("v%0d_valid", i),
            32'(valid), 32'(tbl[i].v));
      check($sformatf("v%0d_ovf", i),
            32'(overflow), 32'(tbl[i].ov));
      check($sformatf("v%0d_pcnt", i),
            32'(pack_cnt), 32'(tbl[i].pc));
    end

    // sec2 mid-pack; ptr was 1, must restart at slot 0
    pulse_clr();
    check("clr_ovf", 32'(overflow), 32'h0);
    send_bits(32'h000003FF, 10);
    pulse_sec2(1'b0, 1'b0);
    check("mid_serr", 32'(sync_err), 32'h1);
    check("mid_valid", 32'(valid), 32'h1);
    check("mid_pcnt", 32'(pack_cnt), 32'd7);
    send_word(32'h13579BDF, 2'b00, 1'b0);
    check("resync_d0", data_0, 32'h13579BDF);
    check("resync_d1", data_1, 32'h0000FFFF);
    check("resync_ovf", 32'(overflow), 32'h1);
    check("resync_pcnt", 32'(pack_cnt), 32'd8);
    pulse_clr();
    check("clr_serr", 32'(sync_err), 32'h0);
    check("clr_ovf2", 32'(overflow), 32'h0);

    // sec2 + epoch at cnt==31: pack dropped
    pulse_sec2(1'b0, 1'b0);
    send_bits(32'hFFFFFFFF, 31);
    pulse_sec2(1'b1, 1'b1);
    check("drop_serr", 32'(sync_err), 32'h1);
    check("drop_pcnt", 32'(pack_cnt), 32'd8);
    check("drop_d0", data_0, 32'h13579BDF);
    check("drop_d1", data_1, 32'h0000FFFF);
    send_word(32'h0F0F0F0F, 2'b01, 1'b0);
    check("after_drop_d0", data_0, 32'h0F0F0F0F);
    check("after_drop_ovf", 32'(overflow), 32'h0);
    check("after_drop_valid", 32'(valid), 32'h1);
    check("after_drop_pcnt", 32'(pack_cnt), 32'd9);

    // ack never touches data
    rd_ack = 2'b11;
    tick();
    rd_ack = 2'b00;
    check("ack_valid", 32'(valid), 32'h0);
    check("ack_d0", data_0, 32'h0F0F0F0F);

    // reset mid-pack
    send_bits(32'h0000AAAA, 20);
    rst         = 1'b1;
    epoch_pulse = 1'b1;
    tick();
    rst         = 1'b0;
    epoch_pulse = 1'b0;
    check_zero("rst_mid");
    send_word(32'h55AA33CC, 2'b00, 1'b0);
    check("fresh_d0", data_0, 32'h55AA33CC);
    check("fresh_d1", data_1, 32'h0);
    check("fresh_valid", 32'(valid), 32'h1);
    check("fresh_pcnt", 32'(pack_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
